// File: rtl/div_ctrl_if.sv
// div_ctrl_if: bundle of every non-clock signal of div_ctrl.
//   req0_* : primary requester (execute stage), with flush
//   req1_* : secondary requester (debug/accelerator), no flush
//   div_*  : start/operand interface to the shared iterative divider
//   rsp_*  : one-cycle response pulse back to the owning port
//   busy_o : controller not idle
// Signal suffixes are from the point of view of div_ctrl.
// modport slave  : used by div_ctrl itself.
// modport master : used by the surrounding logic (requesters + divider).
interface div_ctrl_if;
  logic        req0_valid_i;
  logic [31:0] req0_dividend_i;
  logic [31:0] req0_divisor_i;
  logic [2:0]  req0_op_i;
  logic [4:0]  req0_waddr_i;
  logic        req0_flush_i;
  logic        req0_ready_o;

  logic        req1_valid_i;
  logic [31:0] req1_dividend_i;
  logic [31:0] req1_divisor_i;
  logic [2:0]  req1_op_i;
  logic [4:0]  req1_waddr_i;
  logic        req1_ready_o;

  logic        div_start_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [2:0]  div_op_o;
  logic [4:0]  div_waddr_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_busy_i;

  logic        rsp_valid_o;
  logic        rsp_id_o;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_waddr_o;
  logic        rsp_err_o;
  logic        busy_o;

  modport slave (
    input  req0_valid_i, req0_dividend_i, req0_divisor_i, req0_op_i, req0_waddr_i, req0_flush_i,
    output req0_ready_o,
    input  req1_valid_i, req1_dividend_i, req1_divisor_i, req1_op_i, req1_waddr_i,
    output req1_ready_o,
    output div_start_o, div_dividend_o, div_divisor_o, div_op_o, div_waddr_o,
    input  div_result_i, div_ready_i, div_busy_i,
    output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_waddr_o, rsp_err_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_dividend_i, req0_divisor_i, req0_op_i, req0_waddr_i, req0_flush_i,
    input  req0_ready_o,
    output req1_valid_i, req1_dividend_i, req1_divisor_i, req1_op_i, req1_waddr_i,
    input  req1_ready_o,
    input  div_start_o, div_dividend_o, div_divisor_o, div_op_o, div_waddr_o,
    output div_result_i, div_ready_i, div_busy_i,
    input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_waddr_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer and two-port round-robin arbiter for the shared
// 32-bit iterative divider.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (shared with the divider)
//   bus : div_ctrl_if.slave
//     req0_* / req1_* : requests in, combinational ready out (IDLE only)
//     div_*           : registered start (held for the whole operation),
//                       latched operands/op/tag; result, ready, busy back
//     rsp_*           : response pulse with owner id, selected data, tag,
//                       and a timeout-abort flag
//     busy_o          : state != IDLE
// TIMEOUT bounds the cycles spent in RUN before the operation is aborted;
// it must exceed the divider's 36-cycle latency.
module div_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_q, start_d;
  logic [31:0]   dvd_q, dvd_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [2:0]    op_q, op_d;
  logic [4:0]    waddr_q, waddr_d;
  logic          owner_q, owner_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [4:0]    rsp_waddr_q, rsp_waddr_d;
  logic          rsp_err_q, rsp_err_d;

  logic          v0, v1;
  logic          win;
  logic          ready0, ready1;

  // REM/REMU (op[1] set) return the remainder half of {remainder, quotient}.
  function automatic logic [31:0] sel_result(input logic [63:0] res, input logic rem_sel);
    return rem_sel ? res[63:32] : res[31:0];
  endfunction

  // A flushed port-0 request is invisible to the arbiter.
  assign v0 = bus.req0_valid_i & ~bus.req0_flush_i;
  assign v1 = bus.req1_valid_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    start_d      = start_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    op_d         = op_q;
    waddr_d      = waddr_q;
    owner_d      = owner_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_waddr_d  = rsp_waddr_q;
    rsp_err_d    = rsp_err_q;
    win          = 1'b0;
    ready0       = 1'b0;
    ready1       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (v0 || v1) begin
          // On a tie the port that did not win last time goes first.
          win          = (v0 && v1) ? ~last_grant_q : v1;
          ready0       = ~win;
          ready1       = win;
          dvd_d        = win ? bus.req1_dividend_i : bus.req0_dividend_i;
          dvs_d        = win ? bus.req1_divisor_i  : bus.req0_divisor_i;
          op_d         = win ? bus.req1_op_i       : bus.req0_op_i;
          waddr_d      = win ? bus.req1_waddr_i    : bus.req0_waddr_i;
          owner_d      = win;
          last_grant_d = win;
          start_d      = 1'b1;
          timer_d      = '0;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        timer_d = timer_q + TW'(1);
        // Flush outranks a same-cycle ready: the result is simply dropped.
        if (!owner_q && bus.req0_flush_i) begin
          start_d = 1'b0;
          state_d = S_DRAIN;
        end else if (bus.div_ready_i) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_data_d  = sel_result(bus.div_result_i, op_q[1]);
          rsp_waddr_d = waddr_q;
          rsp_err_d   = 1'b0;
          start_d     = 1'b0;
          state_d     = S_DRAIN;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_data_d  = '0;
          rsp_waddr_d = waddr_q;
          rsp_err_d   = 1'b1;
          start_d     = 1'b0;
          state_d     = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Wait out the divider's trailing ready (zero divisor) or its
        // abort-ready pulse before a new start may be issued.
        start_d = 1'b0;
        if (!bus.div_busy_i && !bus.div_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      start_q      <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      op_q         <= '0;
      waddr_q      <= '0;
      owner_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_waddr_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      start_q      <= start_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      op_q         <= op_d;
      waddr_q      <= waddr_d;
      owner_q      <= owner_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_waddr_q  <= rsp_waddr_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req0_ready_o   = ready0;
  assign bus.req1_ready_o   = ready1;
  assign bus.div_start_o    = start_q;
  assign bus.div_dividend_o = dvd_q;
  assign bus.div_divisor_o  = dvs_q;
  assign bus.div_op_o       = op_q;
  assign bus.div_waddr_o    = waddr_q;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_id_o       = rsp_id_q;
  assign bus.rsp_data_o     = rsp_data_q;
  assign bus.rsp_waddr_o    = rsp_waddr_q;
  assign bus.rsp_err_o      = rsp_err_q;
  assign bus.busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: bench for div_ctrl with a behavioural divider model.
// Stimulus pushes the expected response into a queue on acceptance; a
// separate monitor pops and compares whenever rsp_valid_o is seen.
module tb_div_ctrl;

  logic clk;
  logic rst;

  div_ctrl_if bus ();

  div_ctrl #(.TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [4:0]  waddr;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  wa;
    logic [31:0] q;
  } vec_t;

  rsp_t exp_q[$];
  bit   grant_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  int   last_rsp_cyc = 0;
  bit   stall = 1'b0;
  vec_t tv0[4];
  vec_t tv1[4];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- divider model ----------------
  // Ready 35 cycles after it first sees start (cycle 36 after accept);
  // zero divisor: ready on its first two busy cycles; start dropped early:
  // one abort-ready pulse.
  logic m_busy, m_zero, m_abrt, m_ready;
  int   m_cnt;

  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (!op[0]) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always_comb begin
    m_ready = m_abrt;
    if (m_busy && m_zero && (m_cnt == 1 || m_cnt == 2)) m_ready = 1'b1;
    if (m_busy && !m_zero && !stall && m_cnt == 35) m_ready = 1'b1;
  end

  assign bus.div_ready_i  = m_ready;
  assign bus.div_busy_i   = m_busy | m_abrt;
  assign bus.div_result_i = model_div(bus.div_dividend_o, bus.div_divisor_o, bus.div_op_o);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_zero <= 1'b0; m_abrt <= 1'b0; m_cnt <= 0;
    end else if (!m_busy) begin
      m_abrt <= 1'b0;
      if (bus.div_start_o && !m_abrt) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        m_zero <= (bus.div_divisor_o == 32'd0);
      end
    end else if ((m_zero && m_cnt == 2) || (!m_zero && !stall && m_cnt == 35)) begin
      m_busy <= 1'b0;
    end else if (!bus.div_start_o) begin
      m_busy <= 1'b0;
      m_abrt <= 1'b1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid_o) begin
      rsp_t e;
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d waddr=%0d data=0x%0h, expected no response",
                 bus.rsp_id_o, bus.rsp_waddr_o, bus.rsp_data_o);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rsp_w%0d", e.waddr),
            64'({bus.rsp_id_o, bus.rsp_err_o, bus.rsp_waddr_o, bus.rsp_data_o}), 64'(e));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit p, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [4:0] wa);
    if (!p) begin
      bus.req0_valid_i = v; bus.req0_dividend_i = a; bus.req0_divisor_i = b;
      bus.req0_op_i = op; bus.req0_waddr_i = wa;
    end else begin
      bus.req1_valid_i = v; bus.req1_dividend_i = a; bus.req1_divisor_i = b;
      bus.req1_op_i = op; bus.req1_waddr_i = wa;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit p, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [4:0] wa, input logic [31:0] q,
                      input logic err, input bit push, output int acc);
    int n = 0;
    acc = -1;
    drive(p, 1'b1, a, b, op, wa);
    while (1) begin
      #1;
      if (p ? bus.req1_ready_o : bus.req0_ready_o) begin
        acc = cyc;
        grant_q.push_back(p);
        if (push) exp_q.push_back('{id: p, err: err, waddr: wa, data: q});
        break;
      end
      n++;
      if (n >= 400) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: port %0d tag %0d never accepted", p, wa);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    drive(p, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rsp_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", rsp_cnt, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int a0, a1, a2, d0, d1, n0;

  initial begin
    tv0[0] = '{a: 32'd100,        b: 32'd3, op: 3'b100, wa: 5'd1,  q: 32'd33};
    tv0[1] = '{a: 32'd77,         b: 32'd7, op: 3'b101, wa: 5'd2,  q: 32'd11};
    tv0[2] = '{a: 32'd50,         b: 32'd8, op: 3'b110, wa: 5'd3,  q: 32'd2};
    tv0[3] = '{a: 32'hFFFFFFEC,   b: 32'd6, op: 3'b100, wa: 5'd4,  q: 32'hFFFFFFFD};
    tv1[0] = '{a: 32'd81,         b: 32'd9, op: 3'b100, wa: 5'd10, q: 32'd9};
    tv1[1] = '{a: 32'd1000,       b: 32'd7, op: 3'b111, wa: 5'd11, q: 32'd6};
    tv1[2] = '{a: 32'hFFFFFFFF,   b: 32'd2, op: 3'b101, wa: 5'd12, q: 32'h7FFFFFFF};
    tv1[3] = '{a: 32'hFFFFFFF7,   b: 32'd4, op: 3'b110, wa: 5'd13, q: 32'hFFFFFFFF};

    rst = 1'b1;
    bus.req0_flush_i = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0, '0);
    #1;
    chk("reset_ctrl", 64'({bus.busy_o, bus.div_start_o, bus.rsp_valid_o}), 64'd0);
    chk("reset_div", {bus.div_dividend_o, bus.div_divisor_o}, 64'd0);
    chk("reset_rsp", 64'({bus.div_op_o, bus.div_waddr_o, bus.rsp_data_o, bus.rsp_waddr_o,
                          bus.rsp_id_o, bus.rsp_err_o}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Port 0 DIV 100/7, then port 1 REM -7/2 queued behind it.
    send(1'b0, 32'd100, 32'd7, 3'b100, 5'd5, 32'd14, 1'b0, 1'b1, a0);
    send(1'b1, 32'hFFFFFFF9, 32'd2, 3'b110, 5'd7, 32'hFFFFFFFF, 1'b0, 1'b1, a1);
    chk("t1_latency", 64'(last_rsp_cyc - a0), 64'd37);
    chk("t1_next_accept", 64'(a1 - a0), 64'd38);
    wait_rsp(2, 100);

    // DIVU 5/0: double ready, single response in cycle 3.
    n0 = rsp_cnt;
    send(1'b1, 32'd5, 32'd0, 3'b101, 5'd8, 32'hFFFFFFFF, 1'b0, 1'b1, a2);
    wait_rsp(n0 + 1, 100);
    repeat (6) @(negedge clk);
    chk("z_latency", 64'(last_rsp_cyc - a2), 64'd3);
    chk("z_single_rsp", 64'(rsp_cnt), 64'(n0 + 1));
    chk("z_idle", 64'(bus.busy_o), 64'd0);

    // Both ports continuously valid: grants alternate starting with port 0.
    grant_q.delete();
    n0 = rsp_cnt;
    fork
      for (int i = 0; i < 4; i++)
        send(1'b0, tv0[i].a, tv0[i].b, tv0[i].op, tv0[i].wa, tv0[i].q, 1'b0, 1'b1, d0);
      for (int j = 0; j < 4; j++)
        send(1'b1, tv1[j].a, tv1[j].b, tv1[j].op, tv1[j].wa, tv1[j].q, 1'b0, 1'b1, d1);
    join
    wait_rsp(n0 + 8, 200);
    chk("rr_grants", 64'(grant_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < grant_q.size(); k++)
      chk($sformatf("rr_grant_%0d", k), 64'(grant_q[k]), 64'(k % 2));

    // Flush port 0 in RUN; queued port 1 goes after the drain.
    repeat (2) @(negedge clk);
    n0 = rsp_cnt;
    send(1'b0, 32'd1000, 32'd3, 3'b100, 5'd9, 32'd0, 1'b0, 1'b0, a0);
    fork
      send(1'b1, 32'd50, 32'd5, 3'b101, 5'd21, 32'd10, 1'b0, 1'b1, a1);
      begin
        while (cyc < a0 + 10) @(negedge clk);
        bus.req0_flush_i = 1'b1;
        #1 chk("fl_start_before", 64'(bus.div_start_o), 64'd1);
        @(negedge clk);
        chk("fl_start_after", 64'(bus.div_start_o), 64'd0);
        bus.req0_flush_i = 1'b0;
      end
    join
    chk("fl_accept_cycle", 64'(a1 - a0), 64'd14);
    chk("fl_no_rsp", 64'(rsp_cnt), 64'(n0));
    wait_rsp(n0 + 1, 100);
    repeat (3) @(negedge clk);

    // Stalled divider: timeout abort.
    stall = 1'b1;
    n0 = rsp_cnt;
    send(1'b0, 32'd10, 32'd2, 3'b100, 5'd3, 32'd0, 1'b1, 1'b1, a0);
    wait_rsp(n0 + 1, 150);
    chk("to_latency", 64'(last_rsp_cyc - a0), 64'd65);
    repeat (5) @(negedge clk);
    chk("to_idle", 64'(bus.busy_o), 64'd0);
    stall = 1'b0;

    // Flush in IDLE masks port 0.
    bus.req0_flush_i = 1'b1;
    drive(1'b0, 1'b1, 32'd9, 32'd3, 3'b100, 5'd6);
    #1 chk("mask_ready0", 64'(bus.req0_ready_o), 64'd0);
    @(negedge clk);
    chk("mask_busy", 64'(bus.busy_o), 64'd0);
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    bus.req0_flush_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-RUN.
    send(1'b1, 32'd20, 32'd4, 3'b100, 5'd11, 32'd5, 1'b0, 1'b0, a0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ctrl", 64'({bus.busy_o, bus.div_start_o, bus.rsp_valid_o}), 64'd0);
    chk("rst_div", {bus.div_dividend_o, bus.div_divisor_o}, 64'd0);
    chk("rst_rsp", 64'({bus.div_op_o, bus.div_waddr_o, bus.rsp_data_o, bus.rsp_waddr_o,
                        bus.rsp_id_o, bus.rsp_err_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n0 = rsp_cnt;
    send(1'b0, 32'd100, 32'd7, 3'b111, 5'd17, 32'd2, 1'b0, 1'b1, a0);
    wait_rsp(n0 + 1, 100);
    chk("post_rst_latency", 64'(last_rsp_cyc - a0), 64'd37);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer and two-port arbiter for the shared 32-bit iterative divider. It accepts divide/remainder requests from the execute stage (port 0) and a secondary requester (port 1, e.g. debug or accelerator). It drives the divider's start/operand interface and holds start for the whole operation, as the divider requires. It returns the selected 32-bit result to the winning port, and handles flush, timeout and the divider's post-completion settling.

## Interface
- TIMEOUT, 64, max cycles in RUN before abort; must exceed 36
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req0_valid_i  input  1  port 0 request; operands stable while high until accepted
- req0_dividend_i / req0_divisor_i  input  32 each  port 0 operands
- req0_op_i  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- req0_waddr_i  input  5  destination register tag
- req0_flush_i  input  1  cancel port 0 request/operation
- req0_ready_o  output  1  port 0 accepted this cycle
- req1_valid_i, req1_dividend_i, req1_divisor_i, req1_op_i, req1_waddr_i, req1_ready_o  same as port 0, no flush
- div_start_o  output  1  divider start, registered
- div_dividend_o / div_divisor_o  output  32 each  latched operands
- div_op_o  output  3; div_waddr_o  output  5  latched op/tag
- div_result_i  input  64  {remainder, quotient}
- div_ready_i  input  1  divider result valid
- div_busy_i  input  1  divider not idle
- rsp_valid_o  output  1  one-cycle response pulse
- rsp_id_o  output  1  port that owns the response
- rsp_data_o  output  32  selected result
- rsp_waddr_o  output  5  tag of the completed request
- rsp_err_o  output  1  response is a timeout abort
- busy_o  output  1  state != IDLE

## Operation
- States: IDLE, RUN, DRAIN.
- Effective request: v0 = req0_valid_i & ~req0_flush_i; v1 = req1_valid_i.
- IDLE grant (combinational ready):
  - Only one of v0, v1 → that port wins.
  - Both → round-robin: the port not granted last wins. The last_grant pointer resets to 1, so port 0 wins the first tie.
  - Winner's req_ready_o = 1 for that cycle.
  - On the edge: latch operands, op, tag and owner; update last_grant; div_start_o <= 1; clear timer; → RUN.
- RUN: div_start_o held 1; timer increments each cycle.
  - div_ready_i = 1: capture the result. Result select: rsp_data_o = div_result_i[63:32] if op[1] = 1 (REM/REMU), else div_result_i[31:0].
    - Next cycle: rsp_valid_o = 1, rsp_id_o = owner, rsp_waddr_o = tag, rsp_err_o = 0.
    - div_start_o <= 0; → DRAIN.
  - Owner 0 and req0_flush_i = 1: div_start_o <= 0; no response; → DRAIN. Flush has priority over a same-cycle div_ready_i.
  - timer == TIMEOUT-1, no ready: div_start_o <= 0; next cycle rsp_valid_o = 1, rsp_err_o = 1, rsp_data_o = 0; → DRAIN.
- DRAIN: div_start_o = 0; div_ready_i is ignored.
  - → IDLE when div_busy_i = 0 and div_ready_i = 0.
  - This absorbs the divider's extra ready cycle (zero divisor) and its abort-ready pulse after start drops.
- No new start is issued until DRAIN exits. req*_ready_o is 0 outside IDLE.
- Flush of port 0 in IDLE masks req0, so it is not granted that cycle.
- Responses are not back-pressured. rsp_* hold their values until the next response, except rsp_valid_o, which is a pulse.

## Timing
- Reset (async): state IDLE, last_grant 1, timer 0. Every output is 0, including div_dividend_o, div_divisor_o, div_op_o, div_waddr_o, rsp_data_o, rsp_waddr_o, rsp_id_o and rsp_err_o.
- Reset mid-operation clears the block immediately; the divider shares rst.
- Accept in cycle 0 (req_ready_o = 1) → div_start_o high from cycle 1.
- Nonzero divisor: div_ready_i in cycle 36 → rsp_valid_o in cycle 37. Next accept is no earlier than cycle 38.
- Zero divisor: div_ready_i in cycle 2 (stays high cycle 3) → rsp_valid_o in cycle 3; DRAIN exits after ready falls.
- Flush: div_start_o falls the cycle after flush is seen.
- busy_o is combinational from state.

## Test plan
- Port 0 DIV 100 / 7 → accept cycle 0, rsp_valid_o in cycle 37; rsp_data_o = 14, rsp_id_o = 0, tag echoed.
- Port 1 REM -7 (0xFFFFFFF9) / 2 → rsp_data_o = 0xFFFFFFFF. Then DIVU 5 / 0 → rsp_data_o = 0xFFFFFFFF in cycle 3; the double ready produces only one response.
- Both ports valid continuously, 4 ops each → grants alternate 0, 1, 0, 1, …; no port is starved; every tag is returned once.
- Flush port 0 in cycle 10 of RUN → no rsp_valid_o; DRAIN ignores the abort ready pulse; a queued port 1 request is accepted after div_busy_i = 0.
- Divider model stalls (div_ready_i never asserts), TIMEOUT = 64 → rsp_err_o = 1, rsp_data_o = 0, rsp_valid_o 64 cycles after start, then IDLE.
- Assert rst asynchronously mid-RUN → all outputs 0 without a clock edge; a fresh request after release completes normally.
